// File: rtl/reliable_frame_receiver.sv
// ==== reliable_frame_receiver: bit-serial CRC check, duplicate filter, ACK/NAK return ====
// Revision: 1.0
`default_nettype none

module reliable_frame_receiver #(
  parameter int          DATA_W   = 32,
  parameter logic [15:0] CRC_INIT = 16'hFFFF,
  parameter int          CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:50]       frame_in,
  input  logic              frame_valid,
  output logic              frame_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              ack_valid,
  output logic              ack_ok,
  output logic              ack_seq,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  dup_cnt
);

  localparam logic [15:0]      CRC_POLY = 16'h1021;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [5:0]       LAST_BIT = 6'd32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_DECIDE  = 3'd2,
    S_DELIVER = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  state_t      state;
  logic [1:50] frame_q;
  logic [15:0] crc_q;
  logic [5:0]  bit_cnt;
  logic        expected_seq;

  logic        cur_bit;
  logic        fb;
  logic [15:0] crc_next;
  logic        frame_good;

  // Bits 1..33 (seq then payload) are fed MSB-first into the CRC.
  assign cur_bit    = frame_q[bit_cnt + 6'd1];
  assign fb         = crc_q[15] ^ cur_bit;
  assign crc_next   = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  assign frame_good = (crc_q == frame_q[34:49]) && frame_q[50];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      frame_q      <= '0;
      crc_q        <= '0;
      bit_cnt      <= '0;
      expected_seq <= 1'b0;
      frame_ready  <= 1'b1;
      data_out     <= '0;
      data_valid   <= 1'b0;
      ack_valid    <= 1'b0;
      ack_ok       <= 1'b0;
      ack_seq      <= 1'b0;
      err_cnt      <= '0;
      dup_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_valid) begin
            frame_q     <= frame_in;
            crc_q       <= CRC_INIT;
            bit_cnt     <= '0;
            frame_ready <= 1'b0;
            state       <= S_CHECK;
          end
        end
        S_CHECK: begin
          crc_q   <= crc_next;
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt == LAST_BIT) begin
            state <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          if (!frame_good) begin
            ack_ok    <= 1'b0;
            ack_seq   <= expected_seq;
            ack_valid <= 1'b1;
            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
            state     <= S_ACK;
          end else if (frame_q[1] == expected_seq) begin
            data_out   <= frame_q[2:33];
            data_valid <= 1'b1;
            state      <= S_DELIVER;
          end else begin
            // Retransmission after a lost ACK: re-acknowledge, do not redeliver.
            ack_ok    <= 1'b1;
            ack_seq   <= frame_q[1];
            ack_valid <= 1'b1;
            if (dup_cnt != CNT_MAX) dup_cnt <= dup_cnt + CNT_ONE;
            state     <= S_ACK;
          end
        end
        S_DELIVER: begin
          if (data_ready) begin
            data_valid   <= 1'b0;
            ack_ok       <= 1'b1;
            ack_seq      <= frame_q[1];
            ack_valid    <= 1'b1;
            expected_seq <= ~expected_seq;
            state        <= S_ACK;
          end
        end
        S_ACK: begin
          ack_valid   <= 1'b0;
          frame_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reliable_frame_receiver.sv
// ==== tb_reliable_frame_receiver: directed + randomized checks against a timeline model ====
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_reliable_frame_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:50] frame_in = '0;
  logic        frame_valid = 1'b0;
  logic        data_ready = 1'b0;
  logic        frame_ready;
  logic [31:0] data_out;
  logic        data_valid;
  logic        ack_valid;
  logic        ack_ok;
  logic        ack_seq;
  logic [7:0]  err_cnt;
  logic [7:0]  dup_cnt;

  reliable_frame_receiver #(.DATA_W(32), .CRC_INIT(16'hFFFF), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .frame_in(frame_in), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .ack_valid(ack_valid), .ack_ok(ack_ok), .ack_seq(ack_seq),
    .err_cnt(err_cnt), .dup_cnt(dup_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] crc_calc(input logic [71:0] v, input int n);
    logic [15:0] c;
    logic        f;
    c = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      f = c[15] ^ v[i];
      c = {c[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [1:50] make_frame(input logic seq, input logic [31:0] data,
                                             input logic stop);
    logic [32:0] m;
    m = {seq, data};
    return {seq, data, crc_calc({39'd0, m}, 33), stop};
  endfunction

  // Transaction timeline model: outcome decided at accept, outputs placed at fixed offsets.
  localparam int K_GOOD = 0, K_BAD = 1, K_DUP = 2;
  logic        m_busy = 1'b0, m_exp_seq = 1'b0, m_ack_ok = 1'b0, m_ack_seq = 1'b0;
  logic        m_seq = 1'b0, m_good;
  logic [7:0]  m_err = '0, m_dup = '0;
  logic [31:0] m_data = '0, m_payload = '0;
  logic [32:0] m_bits;
  int          m_t = 0, m_ack_cyc = -1, m_kind = K_GOOD;
  logic        e_ready, e_dv, e_av;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_exp_seq = 1'b0; m_ack_ok = 1'b0; m_ack_seq = 1'b0;
      m_err = '0; m_dup = '0; m_data = '0; m_ack_cyc = -1;
    end else if (m_busy) begin
      if (cyc == m_t + 35) begin
        if (m_kind == K_BAD) begin
          if (m_err != 8'hFF) m_err = m_err + 8'd1;
          m_ack_ok = 1'b0; m_ack_seq = m_exp_seq;
        end else if (m_kind == K_DUP) begin
          if (m_dup != 8'hFF) m_dup = m_dup + 8'd1;
          m_ack_ok = 1'b1; m_ack_seq = m_seq;
        end else begin
          m_data = m_payload;
        end
      end
      if (m_kind == K_GOOD && cyc == m_ack_cyc) begin
        m_ack_ok = 1'b1; m_ack_seq = m_seq; m_exp_seq = ~m_exp_seq;
      end
      if (m_ack_cyc >= 0 && cyc == m_ack_cyc + 1) m_busy = 1'b0;
    end
    e_ready = !m_busy;
    e_dv    = m_busy && m_kind == K_GOOD && cyc >= m_t + 35 && m_ack_cyc < 0;
    e_av    = m_busy && cyc == m_ack_cyc;
    cmp("frame_ready", frame_ready, e_ready);
    cmp("data_valid", data_valid, e_dv);
    cmp("data_out", data_out, m_data);
    cmp("ack_valid", ack_valid, e_av);
    cmp("ack_ok", ack_ok, m_ack_ok);
    cmp("ack_seq", ack_seq, m_ack_seq);
    cmp("err_cnt", err_cnt, m_err);
    cmp("dup_cnt", dup_cnt, m_dup);
    if (rst_n) begin
      if (!m_busy && frame_valid) begin
        m_busy    = 1'b1;
        m_t       = cyc;
        m_seq     = frame_in[1];
        m_payload = frame_in[2:33];
        m_bits    = frame_in[1:33];
        m_good    = (crc_calc({39'd0, m_bits}, 33) == frame_in[34:49]) && frame_in[50];
        m_kind    = !m_good ? K_BAD : (m_seq == m_exp_seq ? K_GOOD : K_DUP);
        m_ack_cyc = (m_kind == K_GOOD) ? -1 : cyc + 35;
      end else if (e_dv && data_ready) begin
        m_ack_cyc = cyc + 1;
      end
    end
  end

  logic rand_rdy = 1'b0;
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 data_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wait_neg(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // Presents a frame until accepted; t is the cycle in which frame_valid & frame_ready held.
  task automatic send(input logic [1:50] f, output int t);
    int          n;
    logic [63:0] r;
    n = 0;
    @(posedge clk); #1 frame_in = f; frame_valid = 1'b1;
    @(negedge clk);
    while (!frame_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    cmp("frame_accept", frame_ready, 1'b1);
    t = cyc;
    @(posedge clk); #1 frame_valid = 1'b0;
    r = {$urandom, $urandom};
    frame_in = r[49:0];
  endtask

  initial begin
    int          t, t2;
    int          idx;
    logic [1:50] f;
    logic [71:0] s;

    s = "123456789";
    cmp("crc_model_check", crc_calc(s, 72), 16'h29B1);

    repeat (3) @(negedge clk);
    cmp("rst_frame_ready", frame_ready, 1'b1);
    cmp("rst_data_valid", data_valid, 1'b0);
    cmp("rst_ack_valid", ack_valid, 1'b0);
    cmp("rst_data_out", data_out, 32'h0);
    cmp("rst_err_cnt", err_cnt, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;

    // Good frame, immediate consumer
    data_ready = 1'b1;
    send(make_frame(1'b0, 32'hDEADBEEF, 1'b1), t);
    wait_neg(t + 34); cmp("t1_dv_early", data_valid, 1'b0);
    wait_neg(t + 35); cmp("t1_dv", data_valid, 1'b1); cmp("t1_data", data_out, 32'hDEADBEEF);
    wait_neg(t + 36); cmp("t1_av", ack_valid, 1'b1); cmp("t1_ok", ack_ok, 1'b1);
    cmp("t1_seq", ack_seq, 1'b0); cmp("t1_ready_low", frame_ready, 1'b0);
    wait_neg(t + 37); cmp("t1_ready", frame_ready, 1'b1); cmp("t1_av_end", ack_valid, 1'b0);

    // CRC MSB corrupted
    do_reset();
    f = make_frame(1'b0, 32'hDEADBEEF, 1'b1);
    f[34] = ~f[34];
    send(f, t);
    wait_neg(t + 35); cmp("t2_av", ack_valid, 1'b1); cmp("t2_ok", ack_ok, 1'b0);
    cmp("t2_seq", ack_seq, 1'b0); cmp("t2_err", err_cnt, 8'd1); cmp("t2_dv", data_valid, 1'b0);

    // Duplicate
    do_reset();
    f = make_frame(1'b0, 32'hDEADBEEF, 1'b1);
    send(f, t); wait_neg(t + 37);
    send(f, t2);
    wait_neg(t2 + 35); cmp("t3_av", ack_valid, 1'b1); cmp("t3_ok", ack_ok, 1'b1);
    cmp("t3_seq", ack_seq, 1'b0); cmp("t3_dup", dup_cnt, 8'd1); cmp("t3_dv", data_valid, 1'b0);
    send(make_frame(1'b1, 32'h12345678, 1'b1), t);
    wait_neg(t + 35); cmp("t3_next_dv", data_valid, 1'b1); cmp("t3_next_data", data_out, 32'h12345678);
    wait_neg(t + 37);

    // Stop bit low
    do_reset();
    send(make_frame(1'b0, 32'hCAFEF00D, 1'b0), t);
    wait_neg(t + 35); cmp("t4_av", ack_valid, 1'b1); cmp("t4_ok", ack_ok, 1'b0);
    cmp("t4_err", err_cnt, 8'd1);
    wait_neg(t + 37);

    // Consumer stalls for 10 cycles
    do_reset();
    data_ready = 1'b0;
    send(make_frame(1'b0, 32'hA5A55A5A, 1'b1), t);
    for (int k = 35; k < 45; k++) begin
      wait_neg(t + k);
      cmp("t5_dv_hold", data_valid, 1'b1);
      cmp("t5_data_hold", data_out, 32'hA5A55A5A);
      cmp("t5_ready_low", frame_ready, 1'b0);
    end
    @(posedge clk); #1 data_ready = 1'b1;
    wait_neg(t + 45); cmp("t5_av_hs", ack_valid, 1'b0);
    wait_neg(t + 46); cmp("t5_av", ack_valid, 1'b1); cmp("t5_ok", ack_ok, 1'b1);

    // Reset during CHECK, then counter saturation
    do_reset();
    send(make_frame(1'b0, 32'h0BADF00D, 1'b1), t);
    wait_neg(t + 9);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    cmp("t6_ready", frame_ready, 1'b1);
    cmp("t6_dv", data_valid, 1'b0);
    cmp("t6_av", ack_valid, 1'b0);
    cmp("t6_data", data_out, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cmp("t6_no_ack", ack_valid, 1'b0);
    end
    for (int k = 0; k < 257; k++) begin
      f = make_frame(1'(k), $urandom, 1'b1);
      f[49] = ~f[49];
      send(f, t);
      if (k == 255) begin
        wait_neg(t + 36);
        cmp("t6_err_sat", err_cnt, 8'hFF);
      end
    end
    wait_neg(t + 36); cmp("t6_err_hold", err_cnt, 8'hFF);

    // Randomized traffic with a stalling consumer
    do_reset();
    rand_rdy = 1'b1;
    for (int k = 0; k < 120; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      f = make_frame(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) != 0));
      if ($urandom_range(0, 9) < 3) begin
        idx = $urandom_range(1, 49);
        f[idx] = ~f[idx];
      end
      send(f, t);
    end
    @(posedge clk); #1 rand_rdy = 1'b0;
    #2 data_ready = 1'b1;
    repeat (60) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reliable_frame_receiver.md
Name: reliable_frame_receiver

Overview:
- Receiving end of the reliable-data link. It accepts the 50-bit frame the sender produces on its s[1:50] bus.
- Checks the frame CRC bit-serially, detects duplicate frames by sequence bit, and delivers good payloads downstream.
- Returns an ACK/NAK pulse to the sender for every accepted frame.
- Sits between the sender's frame bus and the consumer logic.

Parameters:
- DATA_W, 32, payload width. Frame layout below is fixed for 32.
- CRC_INIT, 16'hFFFF, CRC-16-CCITT seed (poly 16'h1021).
- CNT_W, 8, width of the saturating error and duplicate counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_in  in  [1:50]  frame: [1]=seq, [2:33]=data (bit 2 = MSB), [34:49]=CRC (bit 34 = MSB), [50]=stop bit, must be 1.
- frame_valid  in  1  sender presents frame_in.
- frame_ready  out  1  receiver can accept a frame.
- data_out  out  DATA_W  delivered payload.
- data_valid  out  1  data_out valid.
- data_ready  in  1  consumer accepts data_out.
- ack_valid  out  1  one-cycle ACK/NAK strobe.
- ack_ok  out  1  1=ACK, 0=NAK; qualified by ack_valid.
- ack_seq  out  1  sequence bit being acknowledged.
- err_cnt  out  CNT_W  CRC/stop errors; saturates at all-ones.
- dup_cnt  out  CNT_W  duplicate frames; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE, frame_ready=1, data_valid=0, ack_valid=0, ack_ok=0, ack_seq=0.
  - data_out=0, err_cnt=0, dup_cnt=0, expected_seq=0.
  - The frame register and CRC register are cleared.
- Reset mid-operation aborts the frame in flight. No ACK is issued for it.
- State machine: IDLE, CHECK, DECIDE, DELIVER, ACK.
- IDLE:
  - frame_ready=1.
  - On frame_valid & frame_ready (cycle T): latch frame_in, crc=CRC_INIT, bit counter=0, go to CHECK.
  - frame_ready=0 in every other state.
  - frame_in changes while not ready are ignored.
- CHECK:
  - One frame bit per cycle, bits 1..33 in order (seq first, then data MSB-first).
  - Per-bit update: fb = crc[15] ^ bit; crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
  - Occupies T+1..T+33. Go to DECIDE after counter reaches 32.
- DECIDE (T+34): frame is good iff crc == frame[34:49] and frame[50]==1. Decision:
  - Bad frame: ack_ok=0, ack_seq=expected_seq, err_cnt+1 (saturating), go to ACK.
  - Good frame, seq==expected_seq: data_out=frame[2:33], data_valid=1, go to DELIVER.
  - Good frame, seq!=expected_seq (duplicate, sender retransmit after lost ACK): no delivery, ack_ok=1, ack_seq=seq, dup_cnt+1 (saturating), go to ACK.
- DELIVER:
  - data_valid held high and data_out held stable until data_ready=1.
  - On the handshake cycle: data_valid=0, ack_ok=1, ack_seq=seq, expected_seq toggles, go to ACK.
  - data_ready already high on the first DELIVER cycle completes in that cycle.
- ACK: ack_valid=1 for exactly one cycle, then IDLE. frame_ready returns to 1 the cycle after the ack_valid pulse.
- Latency from accept to ack_valid:
  - Bad or duplicate frame: ack_valid at T+35.
  - Good frame: data_valid at T+35; ack_valid the cycle after the data handshake (T+36 minimum).
- ack_ok and ack_seq hold their last value between strobes.
- Wrap-around and saturation:
  - expected_seq is one bit and wraps 1 to 0.
  - Counters stop at 2^CNT_W-1 and never wrap.
- Simultaneous events: none possible; only one frame is in flight. frame_valid during ACK is not accepted until IDLE.

Test Plan:
1. Reset then good frame, seq=0, data=32'hDEADBEEF, CRC from bench golden model, stop=1, data_ready=1 → data_valid at T+35 with data_out=32'hDEADBEEF; ack_valid at T+36 with ack_ok=1, ack_seq=0; expected_seq=1; frame_ready=1 at T+37.
2. Same frame with CRC bit 34 flipped → no data_valid; ack_valid at T+35 with ack_ok=0, ack_seq=0; err_cnt=1.
3. Good frame with seq=0 accepted, then the identical frame resent → second frame: no data_valid; ACK with ack_ok=1, ack_seq=0; dup_cnt=1; expected_seq stays 1.
4. Good frame with stop bit 0 → NAK; err_cnt increments.
5. Good frame with data_ready held low for 10 cycles → data_valid and data_out stable for all 10 cycles; frame_ready=0 throughout; ACK one cycle after data_ready rises.
6. Reset asserted during CHECK (T+10) → all outputs return to reset values immediately; no ack_valid is issued. Then send 256 bad frames → err_cnt saturates at 8'hFF.
